// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a one-entry holding buffer.
//
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, one or two
// stop bits(1). Each bit is held for PRESCALE+1 clocks. The holding buffer lets
// the next word load on the last clock of the final stop bit, so frames can go
// out back-to-back with no idle gap.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   P_DATA          parallel word to send (DATA_WIDTH bits)
//   DATA_valid      producer offers P_DATA
//   DATA_ready      buffer empty, word can be accepted
//   PAR_EN/PAR_TYP  parity enable / 1 = even (XOR), 0 = odd (XNOR)
//   STOP2           1 = two stop bits
//   PRESCALE        bit period in clocks minus 1
//   TX_OUT          serial line, idle high (registered)
//   busy            frame in progress (registered)
//   frame_done      one-cycle pulse after the last clock of the final stop bit
//
// Handshake: a word is taken on any rising edge where DATA_valid && DATA_ready.
// DATA_ready depends only on the buffer state, never on DATA_valid.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_valid,
  output logic                  DATA_ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                state, state_n;
  logic [PRESC_W-1:0]    cnt, cnt_n, presc_r;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DATA_WIDTH-1:0] shreg, buf_data;
  logic                  buf_full, par_en_r, par_bit_r, stop2_r;
  logic                  load, accept, bit_end, last_bit, tx_n, par_calc;
  logic                  tx_r, busy_r, fdone_r;

  assign DATA_ready = !buf_full;
  assign accept     = DATA_valid && !buf_full;
  // Counter never exceeds presc_r, so an all-ones PRESCALE cannot overflow it.
  assign bit_end    = (cnt == presc_r);
  assign par_calc   = PAR_TYP ? ^buf_data : ~^buf_data;

  assign TX_OUT     = tx_r;
  assign busy       = busy_r;
  assign frame_done = fdone_r;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    load     = 1'b0;
    last_bit = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_full) begin
          load    = 1'b1;
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      default: begin
        if (bit_end) begin
          cnt_n = '0;
          case (state)
            S_START: begin
              state_n = S_DATA;
              idx_n   = '0;
            end
            S_DATA: begin
              if (idx == IDX_W'(DATA_WIDTH - 1))
                state_n = par_en_r ? S_PARITY : S_STOP1;
              else
                idx_n = idx + IDX_W'(1);
            end
            S_PARITY: state_n = S_STOP1;
            S_STOP1: begin
              if (stop2_r) state_n = S_STOP2;
              else         last_bit = 1'b1;
            end
            default: last_bit = 1'b1;
          endcase
          // End of the final stop bit: chain straight into the buffered word.
          if (last_bit) begin
            if (buf_full) begin
              load    = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end
        end else begin
          cnt_n = cnt + PRESC_W'(1);
        end
      end
    endcase

    // Line value is decided from the next state so TX_OUT is a plain register.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg[idx_n];
      S_PARITY: tx_n = par_bit_r;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
      presc_r   <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      fdone_r   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      tx_r    <= tx_n;
      busy_r  <= (state_n != S_IDLE);
      fdone_r <= last_bit;
      // Frame configuration is frozen at the transfer into the shift register.
      if (load) begin
        shreg     <= buf_data;
        par_en_r  <= PAR_EN;
        par_bit_r <= par_calc;
        stop2_r   <= STOP2;
        presc_r   <= PRESCALE;
      end
      if (accept) buf_data <= P_DATA;
      buf_full <= (buf_full && !load) || accept;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: driver tasks push an expected frame per accepted
// word; a negedge monitor pops frames and checks the line clock by clock.
module tb_uart_tx_param;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          presc;
    bit          b2b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [15:0] presc = '0;
  logic       tx_out, busy, frame_done;

  logic [4:0] p5 = '0;
  logic       v5 = 1'b0;
  logic       r5, tx5, busy5, fd5;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit abort = 1'b0;

  frame_t exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  uart_tx_param #(.DATA_WIDTH(8), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_valid(data_valid),
    .DATA_ready(data_ready), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .PRESCALE(presc), .TX_OUT(tx_out), .busy(busy),
    .frame_done(frame_done)
  );

  uart_tx_param #(.DATA_WIDTH(5), .PRESC_W(16)) dut5 (
    .clk(clk), .rst(rst), .P_DATA(p5), .DATA_valid(v5),
    .DATA_ready(r5), .PAR_EN(1'b1), .PAR_TYP(1'b0),
    .STOP2(1'b0), .PRESCALE(16'd0), .TX_OUT(tx5), .busy(busy5),
    .frame_done(fd5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: frame as a list of line levels, one entry per bit.
  function automatic frame_t build(input logic [8:0] d, input int w, input bit pe,
                                   input bit pt, input bit s2, input int pr, input bit b2b);
    frame_t f;
    int ones = 0;
    int n = 0;
    f.bits = '1;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < w; i++) begin
      f.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pe) begin
      // even parity: total ones including parity even; odd: total odd
      f.bits[n] = pt ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    f.bits[n] = 1'b1; n++;
    if (s2) begin f.bits[n] = 1'b1; n++; end
    f.nbits = n;
    f.presc = pr;
    f.b2b   = b2b;
    return f;
  endfunction

  task automatic cfg(input bit pe, input bit pt, input bit s2, input int pr);
    par_en  = pe;
    par_typ = pt;
    stop2   = s2;
    presc   = 16'(pr);
  endtask

  // Offer a word; the expectation is pushed at the accepting edge using the
  // configuration that will still be in place at transfer.
  task automatic send(input logic [7:0] d, input bit b2b);
    int n = 0;
    bit acc = 1'b0;
    p_data = d;
    data_valid = 1'b1;
    while (!acc && n < 500) begin
      acc = data_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(build({1'b0, d}, 8, par_en, par_typ, stop2, int'(presc), b2b));
      #1;
      n++;
    end
    data_valid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!data_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!data_ready) fail_now("ready_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !data_ready || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) fail_now("idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  bit     active = 1'b0;
  bit     done_due = 1'b0;
  bit     prev_due;
  frame_t cur;
  int     bi = 0, ci = 0;

  always @(negedge clk) begin
    if (abort || rst) begin
      active   = 1'b0;
      done_due = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      chk("frame_done", 32'(frame_done), 32'(done_due));
      prev_due = done_due;
      done_due = 1'b0;
      if (!active && busy) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          bi = 0;
          ci = 0;
          if (cur.b2b) chk("b2b_gap", 32'(prev_due), 32'd1);
        end
      end
      if (active) begin
        chk("tx_bit", 32'(tx_out), 32'(cur.bits[bi]));
        chk("busy_frame", 32'(busy), 32'd1);
        if (ci == cur.presc) begin
          ci = 0;
          if (bi == cur.nbits - 1) begin
            active   = 1'b0;
            done_due = 1'b1;
          end else begin
            bi++;
          end
        end else begin
          ci++;
        end
      end else begin
        chk("idle_line", 32'({tx_out, busy}), 32'b10);
      end
    end
  end

  initial begin
    int d0;
    frame_t f5;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single frame with even parity, one clock per bit, plus start latency
    cfg(1, 1, 0, 0);
    d0 = done_cnt;
    send(8'hA5, 0);
    chk("latency_pre_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_start", 32'({tx_out, busy}), 32'b01);
    wait_idle();
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // no parity, two stop bits, four clocks per bit
    cfg(0, 1, 1, 3);
    send(8'hA5, 0);
    wait_idle();

    // back-to-back frames
    cfg(0, 0, 0, 0);
    d0 = done_cnt;
    send(8'h01, 0);
    send(8'hFF, 1);
    chk("ready_while_full", 32'(data_ready), 32'd0);
    wait_idle();
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // config change during the data bits of the current frame
    cfg(1, 1, 0, 1);
    send(8'h3C, 0);
    repeat (6) @(posedge clk);
    #1;
    par_typ = 1'b0;
    presc   = 16'd2;
    send(8'hC3, 1);
    wait_idle();

    // reset mid-frame with a word buffered
    cfg(1, 1, 0, 0);
    send(8'h5A, 0);
    send(8'h99, 0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx_out), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(data_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'({tx_out, busy}), 32'b10);

    // DATA_WIDTH=5 build, odd parity
    f5 = build(9'h01F, 5, 1, 0, 0, 0, 0);
    p5 = 5'h1F;
    v5 = 1'b1;
    chk("w5_ready", 32'(r5), 32'd1);
    @(posedge clk);
    #1;
    v5 = 1'b0;
    for (int i = 0; i < f5.nbits; i++) begin
      @(posedge clk);
      #1;
      chk("w5_bit", 32'(tx5), 32'(f5.bits[i]));
      chk("w5_busy", 32'(busy5), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("w5_done", 32'({fd5, busy5}), 32'b10);

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3));
      send(8'($urandom_range(0, 255)), 0);
      wait_ready();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
